// File: rtl/uart_fifo_bridge.sv
// UART bridge: TX byte FIFO feeding a launch FSM, RX FSM filling a show-ahead
// RX FIFO with a sticky overflow flag.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_push,
  output logic       tx_full,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       rx_empty,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  output logic [7:0] uart_din,
  output logic       uart_wr_en,
  input  logic       uart_tx_busy,
  input  logic       uart_rdy,
  input  logic [7:0] uart_dout,
  output logic       uart_rdy_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  // TX path state
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr_ptr;
  logic [AW-1:0] r_tx_rd_ptr;
  logic [AW:0]   r_tx_count;
  tx_state_e     r_tx_state;
  tx_state_e     w_tx_next;
  logic [7:0]    r_uart_din;

  // RX path state
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wr_ptr;
  logic [AW-1:0] r_rx_rd_ptr;
  logic [AW:0]   r_rx_count;
  rx_state_e     r_rx_state;
  rx_state_e     w_rx_next;
  logic          r_rdy_clr;
  logic          r_overflow;

  logic w_tx_full;
  logic w_tx_empty_fifo;
  logic w_tx_push_ok;
  logic w_tx_pop;
  logic w_rx_full;
  logic w_rx_empty_fifo;
  logic w_rx_capture;
  logic w_rx_pop_ok;
  logic w_rx_push_ok;
  logic w_rx_drop;

  assign w_tx_full       = (r_tx_count == CNT_FULL);
  assign w_tx_empty_fifo = (r_tx_count == '0);
  // Full is judged before any launch pop, so a push at full is always lost.
  assign w_tx_push_ok    = tx_push && !w_tx_full;
  assign w_tx_pop        = (r_tx_state == IDLE) && !w_tx_empty_fifo && !uart_tx_busy;

  assign w_rx_full       = (r_rx_count == CNT_FULL);
  assign w_rx_empty_fifo = (r_rx_count == '0);
  assign w_rx_capture    = (r_rx_state == RX_IDLE) && uart_rdy;
  assign w_rx_pop_ok     = rx_pop && !w_rx_empty_fifo;
  // A pop in the same cycle frees the slot, so a receive at full still lands.
  assign w_rx_push_ok    = w_rx_capture && (!w_rx_full || w_rx_pop_ok);
  assign w_rx_drop       = w_rx_capture && w_rx_full && !w_rx_pop_ok;

  // ---------------- TX FSM ----------------
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      IDLE:      if (w_tx_pop)      w_tx_next = LAUNCH;
      LAUNCH:                       w_tx_next = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy)  w_tx_next = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) w_tx_next = IDLE;
      default:                      w_tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= IDLE;
      r_uart_din <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) r_uart_din <= r_tx_mem[r_tx_rd_ptr];
    end
  end

  // ---------------- TX FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_tx_push_ok) r_tx_mem[r_tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push_ok) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
      if (w_tx_pop)     r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
      case ({w_tx_push_ok, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: if (uart_rdy)  w_rx_next = RX_ACK;
      RX_ACK:  if (!uart_rdy) w_rx_next = RX_IDLE;
      default:                w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rdy_clr  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rdy_clr  <= w_rx_capture;
      if (w_rx_drop)    r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_rx_push_ok) r_rx_mem[r_rx_wr_ptr] <= uart_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push_ok) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
      if (w_rx_pop_ok)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
      case ({w_rx_push_ok, w_rx_pop_ok})
        2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------- Outputs ----------------
  assign tx_full      = w_tx_full;
  assign tx_empty     = w_tx_empty_fifo && (r_tx_state == IDLE);
  assign uart_din     = r_uart_din;
  assign uart_wr_en   = (r_tx_state == LAUNCH);
  // Head is masked while empty so stale memory never shows after reset.
  assign rx_data      = w_rx_empty_fifo ? '0 : r_rx_mem[r_rx_rd_ptr];
  assign rx_empty     = w_rx_empty_fifo;
  assign rx_overflow  = r_overflow;
  assign uart_rdy_clr = r_rdy_clr;

endmodule
